// File: rtl/addsub_rr_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_rr_arbiter
//
// Shares a single carry-lookahead adder/subtractor among NREQ requesters.
// A round-robin arbiter picks at most one requester per cycle. That
// requester's operands are fed through the adder, and the result is captured
// in one output register that supports downstream backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]    requester i holds a valid operation
//   req_ready  [NREQ]    one-hot grant; the operation is accepted this cycle
//   req_a      [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b      [NREQ*W]  operand B, same packing as req_a
//   req_m      [NREQ]    mode per requester: 0 = A+B, 1 = A-B
//   res_valid            output register holds a result
//   res_ready            consumer accepts the result
//   res_s      [W]       registered sum / difference
//   res_c                registered carry-out (1 = no borrow when subtracting)
//   res_v                registered signed overflow
//   res_id     [IDW]     requester that produced the result
//
// Parameter limits: NREQ must be between 2 and 8, and 2**IDW must be at
// least NREQ.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// addsub_cla
//
// W-bit two's complement adder/subtractor built from carry-lookahead logic.
// Subtraction is computed as A + ~B + 1.
//
// Ports
//   a, b  [W]  operands
//   m          0 = add, 1 = subtract
//   s     [W]  result, modulo 2**W
//   c          carry[W]
//   v          signed overflow, carry[W] ^ carry[W-1]
// ---------------------------------------------------------------------------
module addsub_cla #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         m,
   output logic [W-1:0] s,
   output logic         c,
   output logic         v
);

   logic [W-1:0] b_eff;
   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;

   assign b_eff    = b ^ {W{m}};
   assign gen      = a & b_eff;
   assign prop     = a ^ b_eff;
   assign carry[0] = m;

   // Every carry is a flat sum of products of generate and propagate terms
   // plus the carry-in. No carry waits on the carry below it.
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_carry
         logic la_carry;

         always_comb begin : lookahead
            logic prop_run;
            la_carry = gen[gi];
            prop_run = prop[gi];
            for (int j = gi - 1; j >= 0; j--) begin
               la_carry = la_carry | (prop_run & gen[j]);
               prop_run = prop_run & prop[j];
            end
            la_carry = la_carry | (prop_run & m);
         end

         assign carry[gi+1] = la_carry;
      end
   endgenerate

   assign s = prop ^ carry[W-1:0];
   assign c = carry[W];
   assign v = carry[W] ^ carry[W-1];

endmodule

module addsub_rr_arbiter #(
   parameter int W    = 4,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_m,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_s,
   output logic              res_c,
   output logic              res_v,
   output logic [IDW-1:0]    res_id
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Sums of the form last + 1 + offset go up to 2*NREQ - 1. Two extra bits
   // hold that without wrapping.
   localparam int SW = IDW + 2;

   state_t            state_reg;
   state_t            state_next;
   logic [IDW-1:0]    last_reg;
   logic [W-1:0]      res_s_reg;
   logic              res_c_reg;
   logic              res_v_reg;
   logic [IDW-1:0]    res_id_reg;

   logic              free;
   logic              issue_ok;
   logic              accept;
   logic [2*NREQ-1:0] valid_dbl;
   logic [2*NREQ-1:0] valid_shift;
   logic [NREQ-1:0]   valid_rot;
   logic [SW-1:0]     rot_amt;
   logic [SW-1:0]     grant_sum;
   logic              grant_found;
   logic [IDW-1:0]    grant_id;
   logic [NREQ-1:0]   lane_sel;

   logic [W-1:0]      op_a;
   logic [W-1:0]      op_b;
   logic              op_m;
   logic [W-1:0]      alu_s;
   logic              alu_c;
   logic              alu_v;

   // -----------------------------------------------------------------------
   // Stage availability. A full register can still take a new result in the
   // same cycle that the consumer takes the old one.
   // -----------------------------------------------------------------------
   assign free     = (state_reg == EMPTY) | res_ready;
   // Reset is asynchronous, so grants must drop while it is held. Waiting
   // for the next clock edge is not enough.
   assign issue_ok = free & ~rst;

   // -----------------------------------------------------------------------
   // Round-robin search. Rotate the request vector so that bit 0 is the
   // requester after last_reg. The lowest set bit of the rotated vector is
   // the winner. Map its offset back to a requester index with a single
   // conditional subtract.
   // -----------------------------------------------------------------------
   assign valid_dbl   = {req_valid, req_valid};
   assign rot_amt     = {2'b00, last_reg} + SW'(1);
   assign valid_shift = valid_dbl >> rot_amt;
   assign valid_rot   = valid_shift[NREQ-1:0];

   always_comb begin
      grant_found = 1'b0;
      grant_sum   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!grant_found && valid_rot[j]) begin
            grant_found = 1'b1;
            grant_sum   = rot_amt + SW'(j);
         end
      end
      if (grant_sum >= SW'(NREQ)) begin
         grant_sum = grant_sum - SW'(NREQ);
      end
   end

   assign grant_id = grant_sum[IDW-1:0];

   // lane_sel depends only on the arbitration. It selects the adder inputs
   // whether or not the stage is free. req_ready also applies the free
   // check, so it never depends on the operand data.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_lane
         assign lane_sel[gi]  = grant_found & (grant_id == IDW'(gi));
         assign req_ready[gi] = lane_sel[gi] & issue_ok;
      end
   endgenerate

   assign accept = |req_ready;

   // -----------------------------------------------------------------------
   // Operand mux into the shared datapath.
   // -----------------------------------------------------------------------
   always_comb begin
      op_a = '0;
      op_b = '0;
      op_m = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (lane_sel[i]) begin
            op_a = req_a[i*W +: W];
            op_b = req_b[i*W +: W];
            op_m = req_m[i];
         end
      end
   end

   addsub_cla #(
      .W (W)
   ) u_addsub (
      .a (op_a),
      .b (op_b),
      .m (op_m),
      .s (alu_s),
      .c (alu_c),
      .v (alu_v)
   );

   // -----------------------------------------------------------------------
   // Output register FSM
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (accept) begin
               state_next = FULL;
            end else if (res_ready) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= EMPTY;
         last_reg   <= IDW'(NREQ - 1);
         res_s_reg  <= '0;
         res_c_reg  <= 1'b0;
         res_v_reg  <= 1'b0;
         res_id_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            last_reg   <= grant_id;
            res_s_reg  <= alu_s;
            res_c_reg  <= alu_c;
            res_v_reg  <= alu_v;
            res_id_reg <= grant_id;
         end
      end
   end

   assign res_valid = (state_reg == FULL);
   assign res_s     = res_s_reg;
   assign res_c     = res_c_reg;
   assign res_v     = res_v_reg;
   assign res_id    = res_id_reg;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_rr_arbiter
//
// Directed and random stimulus for addsub_rr_arbiter. A queue-free reference
// model tracks the output register and the round-robin pointer. It computes
// results with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_addsub_rr_arbiter;

   localparam int W    = 4;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_m;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_s;
   logic              res_c;
   logic              res_v;
   logic [IDW-1:0]    res_id;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_full;
   int m_s, m_c, m_v, m_id, m_last;
   int refill_pct;
   int arrive_pct;
   int saved_s, saved_c, saved_v, saved_id;

   addsub_rr_arbiter #(
      .W    (W),
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_m     (req_m),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_s     (res_s),
      .res_c     (res_c),
      .res_v     (res_v),
      .res_id    (res_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_s    = 0;
      m_c    = 0;
      m_v    = 0;
      m_id   = 0;
      m_last = NREQ - 1;
   endtask

   // Integer arithmetic reference for W = 4 two's complement.
   task automatic ref_op(input int a, input int b, input int m,
                         output int s, output int c, output int v);
      int sa, sb, r;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      if (m != 0) begin
         s = (a - b + 16) % 16;
         c = (a >= b) ? 1 : 0;
         r = sa - sb;
      end else begin
         s = (a + b) % 16;
         c = (a + b >= 16) ? 1 : 0;
         r = sa + sb;
      end
      v = (r > 7 || r < -8) ? 1 : 0;
   endtask

   // Expected winner: the first valid requester after the last winner. It is
   // -1 when nothing can be issued.
   function automatic int exp_grant();
      int idx;
      if (rst !== 1'b0) return -1;
      if (m_full && res_ready !== 1'b1) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (m_last + k) % NREQ;
         if (((req_valid >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input int a, input int b, input int m);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
      req_m[i]        = 1'(m);
      req_valid[i]    = 1'b1;
   endtask

   task automatic set_rand(input int i);
      set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)));
   endtask

   // One clock cycle. Check at the falling edge, then update the model and
   // drive new stimulus just after the rising edge.
   task automatic cycle();
      int g, ga, gb, gm, s, c, v;
      bit rr;
      logic [NREQ-1:0] pend;
      ga = 0; gb = 0; gm = 0;
      @(negedge clk);
      g  = exp_grant();
      rr = res_ready;
      check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      check("res_valid", 32'(res_valid), 32'(m_full));
      check("res_s", 32'(res_s), 32'(m_s));
      check("res_c", 32'(res_c), 32'(m_c));
      check("res_v", 32'(res_v), 32'(m_v));
      check("res_id", 32'(res_id), 32'(m_id));
      if (g >= 0) begin
         ga = int'(req_a[g*W +: W]);
         gb = int'(req_b[g*W +: W]);
         gm = int'(req_m[g]);
      end
      pend = req_valid;
      @(posedge clk);
      #1;
      if (g >= 0) begin
         ref_op(ga, gb, gm, s, c, v);
         m_full = 1'b1;
         m_s    = s;
         m_c    = c;
         m_v    = v;
         m_id   = g;
         m_last = g;
         $display("txn req=%0d a=%0h b=%0h m=%0d -> s=%0h c=%0d v=%0d", g, ga, gb, gm, s, c, v);
         if (int'($urandom_range(0, 99)) < refill_pct) set_rand(g);
         else req_valid[g] = 1'b0;
      end else if (rr) begin
         m_full = 1'b0;
      end
      // A requester that was valid and not granted must still be valid.
      for (int i = 0; i < NREQ; i++) begin
         if (pend[i] && i != g) begin
            assert (req_valid[i] === 1'b1) else $error("requester %0d dropped valid early", i);
         end else if (!req_valid[i] && int'($urandom_range(0, 99)) < arrive_pct) begin
            set_rand(i);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      res_ready  = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_m      = '0;
      refill_pct = 0;
      arrive_pct = 0;
      model_reset();

      // Reset state: all requesters valid, but no grant while rst is high.
      for (int i = 0; i < NREQ; i++) set_rand(i);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_s", 32'(res_s), 32'd0);
      check("rst_c", 32'(res_c), 32'd0);
      check("rst_v", 32'(res_v), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      req_valid = '0;
      rst       = 1'b0;

      // Directed arithmetic cases
      set_req(0, 3, 4, 0);
      cycle();
      check("t1_valid", 32'(res_valid), 32'd1);
      check("t1_s", 32'(res_s), 32'd7);
      check("t1_c", 32'(res_c), 32'd0);
      check("t1_v", 32'(res_v), 32'd0);
      check("t1_id", 32'(res_id), 32'd0);

      set_req(2, 7, 1, 0);
      cycle();
      check("t2_s", 32'(res_s), 32'h8);
      check("t2_c", 32'(res_c), 32'd0);
      check("t2_v", 32'(res_v), 32'd1);
      check("t2_id", 32'(res_id), 32'd2);

      set_req(1, 8, 1, 1);
      cycle();
      check("t3_s", 32'(res_s), 32'h7);
      check("t3_c", 32'(res_c), 32'd1);
      check("t3_v", 32'(res_v), 32'd1);
      check("t3_id", 32'(res_id), 32'd1);

      // All requesters continuously valid: the grant rotates.
      refill_pct = 100;
      for (int i = 0; i < NREQ; i++) set_rand(i);
      repeat (8) cycle();
      refill_pct = 0;
      repeat (NREQ) cycle();

      // Backpressure while FULL: no grants, result frozen.
      res_ready = 1'b0;
      set_rand(1);
      set_rand(3);
      saved_s  = m_s;
      saved_c  = m_c;
      saved_v  = m_v;
      saved_id = m_id;
      repeat (5) cycle();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_s", 32'(res_s), 32'(saved_s));
      check("hold_c", 32'(res_c), 32'(saved_c));
      check("hold_v", 32'(res_v), 32'(saved_v));
      check("hold_id", 32'(res_id), 32'(saved_id));
      res_ready = 1'b1;
      repeat (3) cycle();

      // A single requester granted every free cycle
      refill_pct = 100;
      set_rand(3);
      repeat (3) begin
         cycle();
         check("solo_id", 32'(res_id), 32'd3);
      end
      refill_pct = 0;
      cycle();
      check("solo_id", 32'(res_id), 32'd3);
      cycle();

      // Random traffic with random backpressure
      refill_pct = 60;
      arrive_pct = 25;
      repeat (300) begin
         res_ready = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
         cycle();
      end

      // Asynchronous reset while FULL with requesters valid
      refill_pct = 100;
      arrive_pct = 0;
      res_ready  = 1'b1;
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) set_rand(i);
      repeat (2) cycle();
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(res_valid), 32'd0);
      check("arst_ready", 32'(req_ready), 32'd0);
      check("arst_s", 32'(res_s), 32'd0);
      check("arst_id", 32'(res_id), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("arst_hold_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      set_rand(2);
      set_rand(3);
      rst = 1'b0;
      #1;
      check("post_rst_grant", 32'(req_ready), 32'b0100);
      refill_pct = 0;
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
